// File: rtl/npc_ras_pkg.sv
// Shared NPC control and architecture definitions.
//   - NPC operation encodings and their width
//   - Field positions of LI/BO/BI/BD/AA/LK inside the 26-bit Imm26 slice
//     (instruction bits 6..31, big-endian: instruction bit 6 is Imm26[25])
package npc_ras_pkg;

  localparam int unsigned NPCOP_WIDTH = 3;

  typedef enum logic [NPCOP_WIDTH-1:0] {
    OpPlus4 = 3'd0,
    OpB     = 3'd1,
    OpBc    = 3'd2,
    OpBcctr = 3'd3,
    OpBclr  = 3'd4
  } npc_op_e;

  // Imm26 field ranges
  localparam int unsigned LI_MSB = 25;
  localparam int unsigned LI_LSB = 2;
  localparam int unsigned BO_MSB = 25;
  localparam int unsigned BO_LSB = 21;
  localparam int unsigned BI_MSB = 20;
  localparam int unsigned BI_LSB = 16;
  localparam int unsigned BD_MSB = 15;
  localparam int unsigned BD_LSB = 2;
  localparam int unsigned AA_BIT = 1;
  localparam int unsigned LK_BIT = 0;

  // BO is numbered big-endian: BO[0] is vector bit 4
  localparam int unsigned BO_IGN_COND = 4;  // BO[0]: ignore condition
  localparam int unsigned BO_COND_VAL = 3;  // BO[1]: required CR bit value
  localparam int unsigned BO_IGN_CTR  = 2;  // BO[2]: ignore/no-decrement CTR
  localparam int unsigned BO_CTR_ZERO = 1;  // BO[3]: branch when CTR reaches zero

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address stack.
//   push    : write wdata above the top; overwrites the oldest entry when full
//   pop     : drop the top entry; ignored when empty
//   replace : overwrite the top entry in place, count unchanged
//   top/vld : current top entry and non-empty flag
// Only one of push/pop/replace is expected per cycle; push has priority.
module npc_ras_stack #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                replace,
  input  logic [PC_WIDTH-1:0] wdata,
  output logic [PC_WIDTH-1:0] top,
  output logic                vld
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]     ptr_q, ptr_d, wr_idx;
  logic [PtrW:0]       cnt_q, cnt_d;
  logic                wr_en;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push) begin
      ptr_d  = ptr_q + PtrW'(1);
      wr_idx = ptr_q + PtrW'(1);
      wr_en  = 1'b1;
      if (cnt_q != Full) cnt_d = cnt_q + (PtrW+1)'(1);
    end else if (pop) begin
      if (cnt_q != '0) begin
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - (PtrW+1)'(1);
      end
    end else if (replace) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are masked by vld, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wdata;
  end

  assign top = mem_q[ptr_q];
  assign vld = (cnt_q != '0);

endmodule

// File: rtl/npc_ras.sv
// Next-PC resolution with CTR/LR write-back and a return-address stack
// that predicts BCLR targets and counts return mispredicts.
//   clk, rst_n          : clock, synchronous active-low reset
//   br_valid, stall     : state update only when br_valid=1 and stall=0
//   Op, Imm26           : NPC operation and instruction bits 6..31
//   PC, PCB             : fetch PC, branch instruction PC
//   CRrd, CTRrd, LRrd   : condition register, current CTR and LR
//   NPC                 : resolved next PC (combinational)
//   CTRwd/CTRwe, LRwd/LRwe : CTR and LR write-back
//   ras_top, ras_vld    : predicted return target, stack non-empty
//   mispred, miss_cnt   : registered mispredict pulse, saturating count
module npc_ras
  import npc_ras_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned RAS_DEPTH      = 8,
  parameter int unsigned MISS_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      br_valid,
  input  logic                      stall,
  input  logic [NPCOP_WIDTH-1:0]    Op,
  input  logic [25:0]               Imm26,
  input  logic [PC_WIDTH-1:0]       PC,
  input  logic [PC_WIDTH-1:0]       PCB,
  input  logic [31:0]               CRrd,
  input  logic [PC_WIDTH-1:0]       CTRrd,
  input  logic [PC_WIDTH-1:0]       LRrd,
  output logic [PC_WIDTH-1:0]       NPC,
  output logic [PC_WIDTH-1:0]       CTRwd,
  output logic                      CTRwe,
  output logic [PC_WIDTH-1:0]       LRwd,
  output logic                      LRwe,
  output logic [PC_WIDTH-1:0]       ras_top,
  output logic                      ras_vld,
  output logic                      mispred,
  output logic [MISS_CNT_WIDTH-1:0] miss_cnt
);

  logic [4:0]          bo, bi;
  logic [23:0]         li;
  logic [13:0]         bd;
  logic                aa, lk;
  logic [PC_WIDTH-1:0] ctr_dec, pc_plus4, pcb_plus4, base, li_ext, bd_ext;
  logic                cond_ok, ctr_ok, upd, is_link_op, is_bclr, bclr_taken;
  logic                push, pop, repl, miss;
  logic                mispred_q, mispred_d;
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  assign li = Imm26[LI_MSB:LI_LSB];
  assign bo = Imm26[BO_MSB:BO_LSB];
  assign bi = Imm26[BI_MSB:BI_LSB];
  assign bd = Imm26[BD_MSB:BD_LSB];
  assign aa = Imm26[AA_BIT];
  assign lk = Imm26[LK_BIT];

  assign ctr_dec   = CTRrd - PC_WIDTH'(1);  // wraps 0 -> all-ones
  assign pc_plus4  = PC + PC_WIDTH'(4);
  assign pcb_plus4 = PCB + PC_WIDTH'(4);
  assign base      = aa ? '0 : PCB;
  assign li_ext    = {{(PC_WIDTH-26){li[23]}}, li, 2'b00};
  assign bd_ext    = {{(PC_WIDTH-16){bd[13]}}, bd, 2'b00};

  assign cond_ok = bo[BO_IGN_COND] | (CRrd[bi] == bo[BO_COND_VAL]);
  assign ctr_ok  = bo[BO_IGN_CTR] | ((ctr_dec != '0) ^ bo[BO_CTR_ZERO]);

  always_comb begin
    NPC = pc_plus4;
    case (Op)
      OpPlus4: NPC = pc_plus4;
      OpB:     NPC = base + li_ext;
      OpBc:    NPC = (ctr_ok & cond_ok) ? base + bd_ext : pcb_plus4;
      OpBcctr: NPC = cond_ok ? {CTRrd[PC_WIDTH-1:2], 2'b00} : pcb_plus4;
      OpBclr:  NPC = (ctr_ok & cond_ok) ? {LRrd[PC_WIDTH-1:2], 2'b00} : pcb_plus4;
      default: NPC = pc_plus4;
    endcase
  end

  assign upd        = br_valid & ~stall;
  assign is_bclr    = (Op == OpBclr);
  assign is_link_op = (Op == OpB) | (Op == OpBc) | (Op == OpBcctr);
  assign bclr_taken = is_bclr & ctr_ok & cond_ok;

  // BCCTR never decrements CTR.
  assign CTRwd = ctr_dec;
  assign CTRwe = upd & ((Op == OpBc) | is_bclr) & ~bo[BO_IGN_CTR];
  assign LRwd  = pcb_plus4;
  assign LRwe  = upd & lk & (is_link_op | is_bclr);

  assign push = upd & lk & is_link_op;
  assign pop  = upd & bclr_taken & ~lk;
  assign repl = upd & bclr_taken & lk;

  npc_ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .replace (repl),
    .wdata   (pcb_plus4),
    .top     (ras_top),
    .vld     (ras_vld)
  );

  // Compared against the stack top before this cycle's pop/replace lands.
  assign miss = upd & bclr_taken & (~ras_vld | (ras_top != NPC));

  always_comb begin
    mispred_d  = miss;
    miss_cnt_d = miss_cnt_q;
    if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + MISS_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispred_q  <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      mispred_q  <= mispred_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign mispred  = mispred_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_npc_ras.sv
module tb_npc_ras;
  import npc_ras_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, br_valid, stall;
  logic [2:0]  op;
  logic [25:0] imm;
  logic [31:0] pc, pcb, cr, ctr, lr;
  logic [31:0] npc, ctrwd, lrwd, ras_top;
  logic        ctrwe, lrwe, ras_vld, mispred;
  logic [3:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_ras #(
    .PC_WIDTH       (32),
    .RAS_DEPTH      (8),
    .MISS_CNT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_valid (br_valid),
    .stall    (stall),
    .Op       (op),
    .Imm26    (imm),
    .PC       (pc),
    .PCB      (pcb),
    .CRrd     (cr),
    .CTRrd    (ctr),
    .LRrd     (lr),
    .NPC      (npc),
    .CTRwd    (ctrwd),
    .CTRwe    (ctrwe),
    .LRwd     (lrwd),
    .LRwe     (lrwe),
    .ras_top  (ras_top),
    .ras_vld  (ras_vld),
    .mispred  (mispred),
    .miss_cnt (miss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction field builders (PowerPC I-form / B-form, bits 6..31).
  function automatic logic [25:0] f_b(input logic [23:0] li, input logic aa, input logic lk);
    return {li, aa, lk};
  endfunction

  function automatic logic [25:0] f_bc(input logic [4:0] bo, input logic [4:0] bi,
                                       input logic [13:0] bd, input logic aa, input logic lk);
    return {bo, bi, bd, aa, lk};
  endfunction

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [25:0] imm;
    logic [31:0] pc, pcb, cr, ctr, lr;
    logic        bv, st;
    logic [31:0] e_npc, e_ctrwd;
    logic        e_ctrwe;
    logic [31:0] e_lrwd;
    logic        e_lrwe;
  } vec_t;

  vec_t vecs[$];

  // ---------------- sequential scoreboard ----------------
  typedef struct {
    logic        mis;
    logic [3:0]  cnt;
    logic        vld;
    logic [31:0] top;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_stk[$];   // reference stack, newest at the back
  logic [3:0]  m_cnt;

  // One clock of stimulus. BCLR in sequences always uses BO=10100 (taken).
  task automatic step(input string name, input logic rst, input logic [2:0] o,
                      input logic [25:0] im, input logic [31:0] b_pc,
                      input logic [31:0] l_r, input logic bv, input logic st);
    exp_t e;
    logic lk;
    logic m;
    rst_n = rst; op = o; imm = im; pcb = b_pc; lr = l_r; br_valid = bv; stall = st;
    pc = 32'h1000; cr = 32'h0; ctr = 32'h10;
    lk = im[0];
    m  = 1'b0;
    if (!rst) begin
      m_stk.delete();
      m_cnt = 4'd0;
    end else if (bv && !st) begin
      if (lk && (o == OpB || o == OpBc || o == OpBcctr)) begin
        m_stk.push_back(b_pc + 32'd4);
        if (m_stk.size() > 8) m_stk.delete(0);
      end else if (o == OpBclr) begin
        m = (m_stk.size() == 0) || (m_stk[$] != {l_r[31:2], 2'b00});
        if (lk) begin
          if (m_stk.size() > 0) m_stk[m_stk.size()-1] = b_pc + 32'd4;
        end else if (m_stk.size() > 0) begin
          void'(m_stk.pop_back());
        end
        if (m && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
    end
    e.mis = m;
    e.cnt = m_cnt;
    e.vld = (m_stk.size() != 0);
    e.top = (m_stk.size() != 0) ? m_stk[$] : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({name, "_mispred"}, {31'd0, mispred}, {31'd0, e.mis});
    chk({name, "_miss_cnt"}, {28'd0, miss_cnt}, {28'd0, e.cnt});
    chk({name, "_ras_vld"}, {31'd0, ras_vld}, {31'd0, e.vld});
    if (e.vld) chk({name, "_ras_top"}, ras_top, e.top);
  endtask

  localparam logic [25:0] ImmBLk = 26'h0000_011;  // B, LI=4, LK=1

  function automatic logic [25:0] bclr_imm(input logic lk);
    return f_bc(5'b10100, 5'd0, 14'd0, 1'b0, lk);
  endfunction

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; stall = 1'b0; op = '0; imm = '0;
    pc = '0; pcb = '0; cr = '0; ctr = '0; lr = '0;
    m_cnt = 4'd0;

    //            op        imm                                      pc         pcb        cr         ctr           lr         bv st  npc           ctrwd         we  lrwd       we
    vecs.push_back('{OpPlus4, 26'd0,                                 32'h1000, 32'h800, 32'h0,  32'h10,   32'h0,    1, 0, 32'h1004,     32'hF,        0, 32'h804, 0});
    vecs.push_back('{OpB,     f_b(24'h10, 0, 0),                     32'h1000, 32'h200, 32'h0,  32'h10,   32'h0,    1, 0, 32'h240,      32'hF,        0, 32'h204, 0});
    vecs.push_back('{OpB,     f_b(24'hFFFFFC, 0, 1),                 32'h1000, 32'h200, 32'h0,  32'h10,   32'h0,    1, 0, 32'h1F0,      32'hF,        0, 32'h204, 1});
    vecs.push_back('{OpB,     f_b(24'h40, 1, 0),                     32'h1000, 32'h200, 32'h0,  32'h10,   32'h0,    1, 0, 32'h100,      32'hF,        0, 32'h204, 0});
    vecs.push_back('{OpBc,    f_bc(5'b10100, 5'd2, 14'h10, 0, 0),    32'h1000, 32'h100, 32'h4,  32'h10,   32'h0,    1, 0, 32'h140,      32'hF,        0, 32'h104, 0});
    vecs.push_back('{OpBc,    f_bc(5'b00000, 5'd3, 14'h10, 0, 0),    32'h1000, 32'h300, 32'h0,  32'h1,    32'h0,    1, 0, 32'h304,      32'h0,        1, 32'h304, 0});
    vecs.push_back('{OpBc,    f_bc(5'b00000, 5'd3, 14'h10, 0, 0),    32'h1000, 32'h300, 32'h0,  32'h0,    32'h0,    1, 0, 32'h340,      32'hFFFFFFFF, 1, 32'h304, 0});
    vecs.push_back('{OpBc,    f_bc(5'b00100, 5'd5, 14'h10, 0, 0),    32'h1000, 32'h400, 32'h20, 32'h10,   32'h0,    1, 0, 32'h404,      32'hF,        0, 32'h404, 0});
    vecs.push_back('{OpBc,    f_bc(5'b01100, 5'd5, 14'h10, 0, 0),    32'h1000, 32'h400, 32'h20, 32'h10,   32'h0,    1, 0, 32'h440,      32'hF,        0, 32'h404, 0});
    vecs.push_back('{OpBc,    f_bc(5'b10010, 5'd0, 14'h10, 0, 0),    32'h1000, 32'h500, 32'h0,  32'h1,    32'h0,    1, 0, 32'h540,      32'h0,        1, 32'h504, 0});
    vecs.push_back('{OpBc,    f_bc(5'b10100, 5'd0, 14'h3FFF, 0, 0),  32'h1000, 32'h600, 32'h0,  32'h10,   32'h0,    1, 0, 32'h5FC,      32'hF,        0, 32'h604, 0});
    vecs.push_back('{OpBcctr, f_bc(5'b10000, 5'd0, 14'h0, 0, 0),     32'h1000, 32'h700, 32'h0,  32'h1237, 32'h0,    1, 0, 32'h1234,     32'h1236,     0, 32'h704, 0});
    vecs.push_back('{OpBcctr, f_bc(5'b00100, 5'd5, 14'h0, 0, 1),     32'h1000, 32'h700, 32'h20, 32'h1237, 32'h0,    1, 0, 32'h704,      32'h1236,     0, 32'h704, 1});
    vecs.push_back('{OpBclr,  f_bc(5'b10100, 5'd0, 14'h0, 0, 1),     32'h1000, 32'h800, 32'h0,  32'h10,   32'h5557, 1, 0, 32'h5554,     32'hF,        0, 32'h804, 1});
    vecs.push_back('{OpBclr,  f_bc(5'b10000, 5'd0, 14'h0, 0, 0),     32'h1000, 32'h800, 32'h0,  32'h5,    32'h5557, 1, 0, 32'h5554,     32'h4,        1, 32'h804, 0});
    vecs.push_back('{OpBclr,  f_bc(5'b10010, 5'd0, 14'h0, 0, 0),     32'h1000, 32'h800, 32'h0,  32'h5,    32'h5557, 1, 0, 32'h804,      32'h4,        1, 32'h804, 0});
    vecs.push_back('{OpBc,    f_bc(5'b00000, 5'd3, 14'h10, 0, 1),    32'h1000, 32'h300, 32'h0,  32'h1,    32'h0,    1, 1, 32'h304,      32'h0,        0, 32'h304, 0});
    vecs.push_back('{OpB,     f_b(24'h10, 0, 1),                     32'h1000, 32'h200, 32'h0,  32'h10,   32'h0,    0, 0, 32'h240,      32'hF,        0, 32'h204, 0});
    vecs.push_back('{3'd7,    26'd0,                                 32'h2000, 32'h200, 32'h0,  32'h10,   32'h0,    1, 0, 32'h2004,     32'hF,        0, 32'h204, 0});

    @(negedge clk);
    // Table runs under reset so the stack never moves.
    foreach (vecs[i]) begin
      op = vecs[i].op; imm = vecs[i].imm; pc = vecs[i].pc; pcb = vecs[i].pcb;
      cr = vecs[i].cr; ctr = vecs[i].ctr; lr = vecs[i].lr;
      br_valid = vecs[i].bv; stall = vecs[i].st;
      #1;
      chk($sformatf("vec%0d_npc", i), npc, vecs[i].e_npc);
      chk($sformatf("vec%0d_ctrwd", i), ctrwd, vecs[i].e_ctrwd);
      chk($sformatf("vec%0d_ctrwe", i), {31'd0, ctrwe}, {31'd0, vecs[i].e_ctrwe});
      chk($sformatf("vec%0d_lrwd", i), lrwd, vecs[i].e_lrwd);
      chk($sformatf("vec%0d_lrwe", i), {31'd0, lrwe}, {31'd0, vecs[i].e_lrwe});
      @(negedge clk);
    end

    // Reset with an active push pending: nothing may be captured.
    step("rst", 0, OpB, ImmBLk, 32'h40, 32'h0, 1, 0);
    step("rst2", 0, OpB, ImmBLk, 32'h40, 32'h0, 1, 0);

    // Call then matching return: hit, stack empties.
    step("call", 1, OpB, ImmBLk, 32'h200, 32'h0, 1, 0);
    step("ret", 1, OpBclr, bclr_imm(0), 32'h300, 32'h204, 1, 0);

    // Nine pushes overflow the 8-deep stack; ninth pop misses.
    for (int i = 0; i < 9; i++)
      step($sformatf("ovf_push%0d", i), 1, OpB, ImmBLk, 32'(i * 16), 32'h0, 1, 0);
    for (int i = 0; i < 9; i++)
      step($sformatf("ovf_pop%0d", i), 1, OpBclr, bclr_imm(0), 32'h900, 32'(8 * 16 + 4 - i * 16), 1, 0);
    chk("ovf_miss_cnt", {28'd0, miss_cnt}, 32'd1);
    step("ovf_idle", 1, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);

    // Stalled push is ignored; mid-sequence reset discards pushes.
    step("r44_rst", 0, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);
    step("stall_push", 1, OpB, ImmBLk, 32'h10, 32'h0, 1, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("r44_push%0d", i), 1, OpB, ImmBLk, 32'h100 + 32'(i * 16), 32'h0, 1, 0);
    step("r44_rst1", 0, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);
    step("post_rst_pop", 1, OpBclr, bclr_imm(0), 32'h0, 32'h124, 1, 0);

    // BCLR with LK replaces the top in place.
    step("rep_rst", 0, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);
    step("rep_push0", 1, OpBc, f_bc(5'b10100, 5'd0, 14'h4, 0, 1), 32'h100, 32'h0, 1, 0);
    step("rep_push1", 1, OpBcctr, f_bc(5'b10100, 5'd0, 14'h0, 0, 1), 32'h200, 32'h0, 1, 0);
    step("rep_repl", 1, OpBclr, bclr_imm(1), 32'h300, 32'h204, 1, 0);
    step("rep_pop0", 1, OpBclr, bclr_imm(0), 32'h0, 32'h304, 1, 0);
    // Wrong target: mispredict, entry still consumed.
    step("rep_wrong", 1, OpBclr, bclr_imm(0), 32'h0, 32'h999, 1, 0);
    // Stalled BCLR: no pop, no mispredict.
    step("st_push", 1, OpB, ImmBLk, 32'h400, 32'h0, 1, 0);
    step("st_bclr", 1, OpBclr, bclr_imm(0), 32'h0, 32'h888, 1, 1);
    step("st_after", 1, OpBclr, bclr_imm(0), 32'h0, 32'h404, 1, 0);

    // Saturate the 4-bit miss counter with empty-stack returns.
    step("sat_rst", 0, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 15; i++)
      step($sformatf("sat%0d", i), 1, OpBclr, bclr_imm(0), 32'h0, 32'h40, 1, 0);
    step("sat_hold", 1, OpBclr, bclr_imm(0), 32'h0, 32'h40, 1, 0);
    chk("sat_mispred", {31'd0, mispred}, 32'd1);
    chk("sat_cnt", {28'd0, miss_cnt}, 32'hF);
    step("sat_idle", 1, OpPlus4, 26'd0, 32'h0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
